// File: rtl/my_seg7_scan_n_if.sv
// my_seg7_scan_n_if: control, data and display signals of the seven-segment scanner
interface my_seg7_scan_n_if #(
    parameter int N = 4
);
    logic           en;
    logic           load;
    logic [4*N-1:0] num;
    logic [N-1:0]   dp_in;
    logic [3:0]     bright;
    logic           lzb;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   seg_gnd;
    logic           busy;
    logic           frame_start;
    modport master (output en, load, num, dp_in, bright, lzb, input seg, dp, seg_gnd, busy, frame_start);
    modport slave (input en, load, num, dp_in, bright, lzb, output seg, dp, seg_gnd, busy, frame_start);
endinterface

// File: rtl/my_seg7_scan_n.sv
// my_seg7_scan_n: N-digit multiplexed seven-segment scanner with PWM brightness and double-buffered data
module my_seg7_scan_n #(
    parameter int N       = 4,
    parameter int DWELL_W = 10,
    parameter int BLANK   = 128
) (
    input logic clk,
    input logic rst,
    my_seg7_scan_n_if.slave bus
);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam int D = 1 << DWELL_W;
    localparam logic [16:0] CNT_ON = 17'(D - BLANK);
    localparam logic [111:0] HEX = {7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
                                    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]      d_q, d_d;
    logic [4*N-1:0]     disp_num_q, pend_num_q;
    logic [N-1:0]       disp_dp_q, pend_dp_q;
    logic               busy_q;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [N-1:0]       gnd_q, gnd_d;
    logic               fs_q;
    logic               wrap, boundary, on, run, cur_dp, cur_nz;
    logic [3:0]         dig;
    logic [6:0]         hex_idx;
    logic [N-1:0]       nz;
    logic [16:0]        lim_b, lim;

    assign wrap     = &cnt_q;
    assign boundary = wrap && d_q == DW'(N - 1);
    assign cnt_d    = cnt_q + 1'b1;
    assign d_d      = (N == 1 || d_q == DW'(N - 1)) ? '0 : d_q + 1'b1;
    assign lim_b    = (17'(bus.bright) + 17'd1) << (DWELL_W - 4);
    assign lim      = (lim_b < CNT_ON) ? lim_b : CNT_ON;
    assign on       = bus.en && cnt_q != '0 && 17'(cnt_q) < lim;
    assign hex_idx  = 7'(dig) * 7'd7;

    // nz[i] marks that some digit at or above i is nonzero
    always_comb begin
        nz     = '0;
        run    = 1'b0;
        dig    = '0;
        cur_dp = 1'b0;
        cur_nz = 1'b0;
        gnd_d  = '1;
        for (int i = N - 1; i >= 0; i--) begin
            run   = run | (|disp_num_q[4*i +: 4]);
            nz[i] = run;
        end
        for (int i = 0; i < N; i++) begin
            if (d_q == DW'(i)) begin
                dig    = disp_num_q[4*i +: 4];
                cur_dp = disp_dp_q[i];
                cur_nz = nz[i];
            end
            gnd_d[i] = !(bus.en && d_q == DW'(i));
        end
        seg_d = (on && !(bus.lzb && d_q != '0 && !cur_nz)) ? HEX[hex_idx +: 7] : 7'd0;
        dp_d  = on && cur_dp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            d_q        <= '0;
            disp_num_q <= '0;
            disp_dp_q  <= '0;
            pend_num_q <= '0;
            pend_dp_q  <= '0;
            busy_q     <= 1'b0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            gnd_q      <= '1;
            fs_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (wrap) d_q <= d_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            gnd_q <= gnd_d;
            fs_q  <= boundary;
            // a load landing on the boundary bypasses the pending buffer
            if (boundary && (bus.load || busy_q)) begin
                disp_num_q <= bus.load ? bus.num : pend_num_q;
                disp_dp_q  <= bus.load ? bus.dp_in : pend_dp_q;
                busy_q     <= 1'b0;
            end else if (bus.load) begin
                pend_num_q <= bus.num;
                pend_dp_q  <= bus.dp_in;
                busy_q     <= 1'b1;
            end
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.seg_gnd     = gnd_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_my_seg7_scan_n.sv
// tb_my_seg7_scan_n: directed checks of the scanner with N=4, D=32, CNT_ON=28
module tb_my_seg7_scan_n;
    logic clk, rst;
    int   cyc, n_chk, n_err;

    my_seg7_scan_n_if #(.N(4)) bus ();
    my_seg7_scan_n #(.N(4), .DWELL_W(5), .BLANK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input logic [15:0] n, input logic [3:0] p);
        bus.num   = n;
        bus.dp_in = p;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg"}, 32'(bus.seg), 32'h0);
        chk({tag, " dp"}, 32'(bus.dp), 32'h0);
        chk({tag, " gnd"}, 32'(bus.seg_gnd), 32'hF);
        chk({tag, " busy"}, 32'(bus.busy), 32'h0);
        chk({tag, " fs"}, 32'(bus.frame_start), 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc = 0;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.load = 1'b0;
        bus.num = '0;
        bus.dp_in = '0;
        bus.bright = 4'd15;
        bus.lzb = 1'b0;
        repeat (3) tick();
        chk_reset("rst");
        rst = 1'b0;
        cyc = 0;
        at(1);   chk("c1 gnd", 32'(bus.seg_gnd), 32'hE);
                 chk("c1 seg", 32'(bus.seg), 32'h0);
        at(2);   chk("c2 seg zero", 32'(bus.seg), 32'h7E);
        at(10);  do_load(16'h1234, 4'b0100);
                 chk("busy set", 32'(bus.busy), 32'h1);
        at(20);  chk("old value", 32'(bus.seg), 32'h7E);
        at(127); chk("busy hold", 32'(bus.busy), 32'h1);
                 chk("fs before", 32'(bus.frame_start), 32'h0);
        at(128); chk("fs pulse", 32'(bus.frame_start), 32'h1);
                 chk("busy clr", 32'(bus.busy), 32'h0);
        at(129); chk("fs one", 32'(bus.frame_start), 32'h0);
                 chk("d0 gnd", 32'(bus.seg_gnd), 32'hE);
                 chk("d0 cnt0", 32'(bus.seg), 32'h0);
        at(130); chk("d0 seg", 32'(bus.seg), 32'h33);
                 chk("d0 dp", 32'(bus.dp), 32'h0);
        at(156); chk("d0 cnt27", 32'(bus.seg), 32'h33);
        at(157); chk("d0 cnt28", 32'(bus.seg), 32'h0);
        at(165); chk("d1 seg", 32'(bus.seg), 32'h79);
                 chk("d1 gnd", 32'(bus.seg_gnd), 32'hD);
        at(202); chk("d2 seg", 32'(bus.seg), 32'h6D);
                 chk("d2 dp", 32'(bus.dp), 32'h1);
                 chk("d2 gnd", 32'(bus.seg_gnd), 32'hB);
        at(226); chk("d3 seg", 32'(bus.seg), 32'h30);
                 chk("d3 gnd", 32'(bus.seg_gnd), 32'h7);
        at(256); bus.bright = 4'd0;
        at(258); chk("br0 cnt1", 32'(bus.seg), 32'h33);
        at(259); chk("br0 cnt2", 32'(bus.seg), 32'h0);
        at(288); bus.bright = 4'd7;
        at(304); chk("br7 cnt15", 32'(bus.seg), 32'h79);
        at(305); chk("br7 cnt16", 32'(bus.seg), 32'h0);
        at(320); bus.bright = 4'd15;
        at(330); bus.lzb = 1'b1;
                 do_load(16'h0050, 4'b0000);
        at(340); chk("lzb busy", 32'(bus.busy), 32'h1);
        at(386); chk("lzb d0", 32'(bus.seg), 32'h7E);
        at(418); chk("lzb d1", 32'(bus.seg), 32'h5B);
        at(450); chk("lzb d2", 32'(bus.seg), 32'h0);
                 chk("lzb d2 gnd", 32'(bus.seg_gnd), 32'hB);
        at(482); chk("lzb d3", 32'(bus.seg), 32'h0);
        at(490); bus.lzb = 1'b0;
        at(492); chk("nolzb d3", 32'(bus.seg), 32'h7E);
        at(639); do_load(16'hABCD, 4'b0001);
                 chk("bnd busy", 32'(bus.busy), 32'h0);
                 chk("bnd fs", 32'(bus.frame_start), 32'h1);
        at(641); chk("bnd busy2", 32'(bus.busy), 32'h0);
        at(642); chk("bnd seg", 32'(bus.seg), 32'h3D);
                 chk("bnd dp", 32'(bus.dp), 32'h1);
        at(768); chk("fs 768", 32'(bus.frame_start), 32'h1);
                 bus.en = 1'b0;
        at(770); chk("en0 seg", 32'(bus.seg), 32'h0);
                 chk("en0 dp", 32'(bus.dp), 32'h0);
                 chk("en0 gnd", 32'(bus.seg_gnd), 32'hF);
        at(800); chk("en0 gnd2", 32'(bus.seg_gnd), 32'hF);
        at(850); chk("en0 seg2", 32'(bus.seg), 32'h0);
        at(895); bus.en = 1'b1;
        at(896); chk("en0 fs", 32'(bus.frame_start), 32'h1);
        at(897); chk("en1 gnd", 32'(bus.seg_gnd), 32'hE);
        at(900); do_load(16'h9999, 4'b1111);
                 chk("pre-rst busy", 32'(bus.busy), 32'h1);
        at(1100);
        rst = 1'b1;
        tick();
        chk_reset("midrst");
        rst = 1'b0;
        cyc = 0;
        at(1);   chk("rr gnd", 32'(bus.seg_gnd), 32'hE);
        at(127); chk("rr fs early", 32'(bus.frame_start), 32'h0);
        at(128); chk("rr fs", 32'(bus.frame_start), 32'h1);
                 chk("rr busy", 32'(bus.busy), 32'h0);
        at(130); chk("rr discard", 32'(bus.seg), 32'h7E);
                 chk("rr dp", 32'(bus.dp), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/my_seg7_scan_n.md
MY_SEG7_SCAN_N -- requirements
Module: my_seg7_scan_n

Interface
REQ-001 SHALL have parameter N, default 4: digit count, 1..8.
REQ-002 SHALL have parameter DWELL_W, default 10: dwell counter width, 5..16; dwell length D = 2^DWELL_W cycles.
REQ-003 SHALL have parameter BLANK, default 128: guard cycles at end of each dwell, 1..D/2; CNT_ON = D - BLANK.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: 0 blanks all segments and digits.
REQ-007 SHALL have port load, input, 1: one-cycle strobe capturing num/dp_in.
REQ-008 SHALL have port num, input, 4*N: hex digits, digit i = num[4i+3:4i].
REQ-009 SHALL have port dp_in, input, N: decimal point per digit.
REQ-010 SHALL have port bright, input, 4: brightness 0..15.
REQ-011 SHALL have port lzb, input, 1: leading-zero blanking enable.
REQ-012 SHALL have port seg, output, 7: segments a..g as bits 6..0, active high.
REQ-013 SHALL have port dp, output, 1: decimal point, active high.
REQ-014 SHALL have port seg_gnd, output, N: digit commons, active low, at most one bit low.
REQ-015 SHALL have port busy, output, 1: loaded data pending, not yet displayed.
REQ-016 SHALL have port frame_start, output, 1: one-cycle pulse at start of digit-0 dwell.

Function
REQ-017 SHALL keep dwell counter cnt (DWELL_W bits), wrapping D-1 -> 0, and digit index d, advancing d -> d+1 (N-1 -> 0) when cnt wraps.
REQ-018 SHALL register all outputs; outputs in cycle k reflect cnt, d and display registers of cycle k-1.
REQ-019 SHALL drive seg_gnd with bit d low, all others high, for the whole dwell of digit d when en=1; all ones when en=0.
REQ-020 SHALL compute lim = min(CNT_ON, (bright+1) * D/16); seg/dp SHALL be nonzero only when en=1 and 1 <= cnt < lim.
REQ-021 SHALL encode hex: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, B=0011111, C=1001110, D=0111101, E=1001111, F=1000111.
REQ-022 SHALL, with lzb=1, blank seg (not dp) of digit i >= 1 when digits i..N-1 of the display register are all zero; digit 0 never blanked.
REQ-023 SHALL double-buffer: load captures num/dp_in into pending registers and sets busy next cycle; a later load before transfer overwrites pending.
REQ-024 SHALL define the frame boundary as cnt = D-1 and d = N-1; at it, if busy, pending copies to display registers and busy clears next cycle.
REQ-025 SHALL, on load coinciding with a frame boundary, copy the incoming num/dp_in directly to display registers and leave busy = 0.
REQ-026 SHALL pulse frame_start for exactly one cycle, the cycle after the frame boundary (outputs first showing digit 0), independent of en.
REQ-027 SHALL keep the counter and digit scan running when en=0; en affects outputs only.
REQ-028 SHALL, for N=1, keep d fixed at 0 and use no zero-width index.

Reset
REQ-029 SHALL, while rst=1, set cnt=0, d=0, display and pending registers 0, busy=0, seg=0, dp=0, seg_gnd all ones, frame_start=0.
REQ-030 SHALL take reset priority over load; rst mid-frame SHALL discard pending data and restart at digit 0, cnt 0.
REQ-031 SHALL assert first frame_start one cycle after the first frame boundary following rst release (cycle N*D after release).

Verification (N=4, DWELL_W=5, BLANK=4: D=32, CNT_ON=28)
REQ-032 SHALL test load num=16'h1234, bright=15, en=1 -> after transfer, digit 0 dwell: seg_gnd=1110, seg=0110011 for cycles cnt 1..27 (+1 latency), 0 elsewhere; digit 3: seg_gnd=0111, seg=0110000.
REQ-033 SHALL test bright=0 -> seg active only cnt 1..1 (lim=2); bright=7 -> cnt 1..15.
REQ-034 SHALL test lzb=1, num=16'h0050 -> digits 3 and 2 blank, digit 1 shows 5, digit 0 shows 0; lzb=0 -> digit 3 shows 1111110.
REQ-035 SHALL test load mid-frame -> busy=1 until frame boundary, old value displayed until frame_start, new value thereafter; load exactly at boundary -> new value shown, busy stays 0.
REQ-036 SHALL test en=0 for one frame -> seg=0, dp=0, seg_gnd=1111, frame_start still pulses every 128 cycles.
REQ-037 SHALL test rst asserted during digit 2 with busy=1 -> next cycle all outputs at reset values, busy=0, frame_start 128 cycles after release.
